writeback_unit: RTL and testbench

//  Writer side of the 32x32 register file write port (RegWrite/writeReg/writeData).

---
 rtl/writeback_unit.sv | 84 ++++++++
 tb/tb_writeback_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU and load results into one registered register-file
// write per cycle and tracks pending destinations for RAW hazard stalls.
module writeback_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       iss_valid,
  input  logic [$clog2(NREGS)-1:0]   iss_rd,
  input  logic                       alu_valid,
  input  logic [$clog2(NREGS)-1:0]   alu_rd,
  input  logic [XLEN-1:0]            alu_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [$clog2(NREGS)-1:0]   ld_rd,
  input  logic [XLEN-1:0]            ld_data,
  input  logic [$clog2(NREGS)-1:0]   chk_rs1,
  input  logic [$clog2(NREGS)-1:0]   chk_rs2,
  output logic                       busy1,
  output logic                       busy2,
  output logic                       RegWrite,
  output logic [$clog2(NREGS)-1:0]   writeReg,
  output logic [XLEN-1:0]            writeData,
  output logic [CNT_W-1:0]           wb_count
);

  localparam int unsigned IDX_W = $clog2(NREGS);

  logic             sel_valid_c;
  logic [IDX_W-1:0] sel_rd_c;
  logic [XLEN-1:0]  sel_data_c;
  logic             commit_c;
  logic [NREGS-1:0] sb;
  logic [NREGS-1:0] sb_next_c;

  // ALU wins arbitration; load is only accepted when the ALU is idle
  always_comb begin
    ld_ready    = ~alu_valid;
    sel_valid_c = alu_valid | ld_valid;
    sel_rd_c    = alu_valid ? alu_rd   : ld_rd;
    sel_data_c  = alu_valid ? alu_data : ld_data;
    commit_c    = sel_valid_c && (sel_rd_c != '0);
  end

  // Scoreboard update: clear the committing index, then set the newly issued one
  always_comb begin
    sb_next_c = sb;
    if (commit_c) begin
      sb_next_c[sel_rd_c] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      sb_next_c[iss_rd] = 1'b1;
    end
    sb_next_c[0] = 1'b0;
  end

  // Registered write port, commit counter and pending-write scoreboard
  always_ff @(posedge clk) begin
    if (!reset) begin
      RegWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
      wb_count  <= '0;
      sb        <= '0;
    end else begin
      RegWrite <= commit_c;
      sb       <= sb_next_c;
      if (commit_c) begin
        writeReg  <= sel_rd_c;
        writeData <= sel_data_c;
        wb_count  <= wb_count + CNT_W'(1);
      end
    end
  end

  // Hazard view: pending bit, or the write on the port this cycle not yet in the file
  always_comb begin
    busy1 = sb[chk_rs1] | (RegWrite && (writeReg == chk_rs1) && (chk_rs1 != '0));
    busy2 = sb[chk_rs2] | (RegWrite && (writeReg == chk_rs2) && (chk_rs2 != '0));
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus pushes expected writes, a forked
// monitor pops and compares on every RegWrite.
module tb_writeback_unit;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        busy1;
  logic        busy2;
  logic        RegWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [31:0] wb_count;

  wr_t         exp_q[$];
  logic [31:0] exp_count;
  int          n_tests;
  int          n_fail;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy1(busy1), .busy2(busy2),
    .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
    .wb_count(wb_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back('{rd: rd, data: data});
    exp_count = exp_count + 32'd1;
  endtask

  initial begin
    wr_t w;
    n_tests = 0;
    n_fail  = 0;
    exp_count = '0;
    idle();
    chk_rs1 = '0;
    chk_rs2 = '0;

    // Monitor: every presented write must match the oldest expected write
    fork
      forever begin
        @(negedge clk);
        if (RegWrite === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", writeReg, writeData);
          end else begin
            w = exp_q.pop_front();
            check("wr_rd", 32'(writeReg), 32'(w.rd));
            check("wr_data", writeData, w.data);
          end
        end
      end
    join_none

    // 1: reset held with an ALU result offered
    reset = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hAAAA_0004;
    step();
    step();
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_wb_count", wb_count, 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    for (int i = 0; i < 32; i++) begin
      chk_rs1 = 5'(i);
      #1;
      check("rst_busy1", 32'(busy1), 32'd0);
    end
    idle();
    reset = 1'b1;
    step();

    // 2: ALU commit and busy window
    iss_valid = 1'b1; iss_rd = 5'd5;
    step();
    iss_valid = 1'b0; chk_rs1 = 5'd5;
    #1;
    check("pend_busy1_5", 32'(busy1), 32'd1);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    expect_wr(5'd5, 32'hDEAD_BEEF);
    step();
    alu_valid = 1'b0;
    #1;
    check("inflight_busy1_5", 32'(busy1), 32'd1);
    step();
    check("done_busy1_5", 32'(busy1), 32'd0);

    // 3: ALU/load conflict
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0333;
    ld_valid  = 1'b1; ld_rd  = 5'd7; ld_data  = 32'h0000_0777;
    #1;
    check("conflict_ld_ready", 32'(ld_ready), 32'd0);
    expect_wr(5'd3, 32'h0000_0333);
    step();
    alu_valid = 1'b0;
    #1;
    check("load_ld_ready", 32'(ld_ready), 32'd1);
    expect_wr(5'd7, 32'h0000_0777);
    step();
    ld_valid = 1'b0;
    step();
    check("conflict_wb_count", wb_count, exp_count);

    // 4: x0 results dropped, x0 never pending
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
    step();
    alu_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h0000_5678;
    #1;
    check("x0_ld_ready", 32'(ld_ready), 32'd1);
    check("x0_regwrite", 32'(RegWrite), 32'd0);
    step();
    ld_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd0; chk_rs1 = 5'd0; chk_rs2 = 5'd0;
    step();
    iss_valid = 1'b0;
    #1;
    check("x0_regwrite2", 32'(RegWrite), 32'd0);
    check("x0_busy1", 32'(busy1), 32'd0);
    check("x0_busy2", 32'(busy2), 32'd0);
    check("x0_wb_count", wb_count, exp_count);

    // 5: same-index clear and set in one cycle keeps the index pending
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0909_0909;
    expect_wr(5'd9, 32'h0909_0909);
    step();
    idle();
    chk_rs2 = 5'd9;
    step();
    check("younger_busy2_9", 32'(busy2), 32'd1);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9999_0000;
    expect_wr(5'd9, 32'h9999_0000);
    step();
    alu_valid = 1'b0;
    step();
    check("cleared_busy2_9", 32'(busy2), 32'd0);

    // 6a: counter wrap
    force dut.wb_count = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count;
    exp_count = 32'hFFFF_FFFF;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h0000_0002;
    expect_wr(5'd2, 32'h0000_0002);
    step();
    alu_valid = 1'b0;
    #1;
    check("wrap_wb_count", wb_count, 32'd0);
    step();

    // 6b: reset asserted while a load is offered
    iss_valid = 1'b1; iss_rd = 5'd12;
    step();
    iss_valid = 1'b0;
    chk_rs1 = 5'd12;
    ld_valid = 1'b1; ld_rd = 5'd12; ld_data = 32'h0C0C_0C0C;
    reset = 1'b0;
    #1;
    check("rst_mid_ld_ready", 32'(ld_ready), 32'd1);
    step();
    check("rst_mid_regwrite", 32'(RegWrite), 32'd0);
    check("rst_mid_busy1_12", 32'(busy1), 32'd0);
    ld_valid = 1'b0;
    reset = 1'b1;
    step();
    step();
    check("post_rst_regwrite", 32'(RegWrite), 32'd0);
    check("post_rst_wb_count", wb_count, 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
